// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding, word/strobe sizes, latency counter width.
package dmem_pkg;
  localparam int WORD_BYTES = 4;
  localparam int STRB_WD    = 4;
  localparam int DATA_WD    = WORD_BYTES * 8;
  localparam int LAT_CNT_WD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_ram.sv
// Single-port byte-enabled RAM, 2^DEPTH_LOG2 x 32; write lands at the edge, read data registered one edge after re.
// No backpressure: re/we are honoured every cycle they are asserted.
import dmem_pkg::*;

module dmem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [STRB_WD-1:0]    be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WD-1:0]    wdata,
  output logic [DATA_WD-1:0]    rdata
);
  logic [DATA_WD-1:0] mem [2**DEPTH_LOG2];

  // Array contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WD; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: stores complete in IDLE at 1/cycle, loads return READ_LATENCY cycles later and hold until Read_data_Ready.
// DMEM_RANGE_CHECK_EN: out-of-range accesses drop stores, return 0 on loads and pulse Mem_Err; otherwise upper bits alias.
import dmem_pkg::*;

module dmem_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic        Mem_Err
);
  state_t                  state;
  logic [LAT_CNT_WD-1:0]   cnt;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [DEPTH_LOG2-1:0]   ram_idx;
  logic [DATA_WD-1:0]      ram_rdata;
  logic                    oor, oor_q, err_q;
  logic                    wr_acc, rd_acc, ram_we, ram_re;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = |Address[31:DEPTH_LOG2+2];
`else
  assign oor = 1'b0;
`endif

  assign wr_acc  = (state == IDLE) && MemWrite;
  assign rd_acc  = (state == IDLE) && MemRead && !MemWrite;
  assign ram_we  = wr_acc && !oor;
  // One RAM port: the live address in IDLE, the latched one while a load is pending.
  assign ram_idx = (state == IDLE) ? Address[DEPTH_LOG2+1:2] : addr_q;
  assign ram_re  = (rd_acc && (READ_LATENCY == 1)) ||
                   ((state == RD_WAIT) && (cnt == LAT_CNT_WD'(1)));

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .be    (Write_strb),
    .idx   (ram_idx),
    .wdata (Write_data),
    .rdata (ram_rdata)
  );

  assign Read_data = oor_q ? '0 : ram_rdata;
  assign Mem_Err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      Mem_Req_Ready   <= 1'b1;
      Read_data_Valid <= 1'b0;
      cnt             <= '0;
      addr_q          <= '0;
      oor_q           <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_acc) begin
            err_q <= oor;
          end else if (rd_acc) begin
            addr_q        <= Address[DEPTH_LOG2+1:2];
            oor_q         <= oor;
            cnt           <= LAT_CNT_WD'(READ_LATENCY - 1);
            Mem_Req_Ready <= 1'b0;
            if (READ_LATENCY == 1) begin
              state           <= RESP;
              Read_data_Valid <= 1'b1;
              err_q           <= oor;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cnt <= cnt - LAT_CNT_WD'(1);
          // Counter hits zero at this edge: RAM word is captured alongside Valid.
          if (cnt == LAT_CNT_WD'(1)) begin
            state           <= RESP;
            Read_data_Valid <= 1'b1;
            err_q           <= oor_q;
          end
        end
        RESP: begin
          if (Read_data_Ready) begin
            state           <= IDLE;
            Read_data_Valid <= 1'b0;
            Mem_Req_Ready   <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          Read_data_Valid <= 1'b0;
          Mem_Req_Ready   <= 1'b1;
        end
      endcase
    end
  end

  // A requester asserting both strobes loses the read silently in hardware.
  a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && MemRead && MemWrite));
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus tasks queue expected load words, a negedge monitor pops on each handshake.
// Range-check expectations follow DMEM_RANGE_CHECK_EN when the bench is built with it.
module tb_dmem_responder;
  localparam int DL  = 10;
  localparam int LAT = 2;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic        MemRead, MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic        Mem_Err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .Address         (Address),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .Mem_Err         (Mem_Err)
  );

  always #5 clk = ~clk;

  function automatic logic is_oor(input logic [31:0] a);
    return RC && (a[31:DL+2] != '0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (!rst && Read_data_Valid && Read_data_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got %h expected none", Read_data);
      end else begin
        check("resp_data", Read_data, exp_q.pop_front());
      end
    end
  end

  // Tasks start and end at posedge+1.
  task automatic wait_ready(input string name);
    int t = 0;
    while (!Mem_Req_Ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 32'(Mem_Req_Ready), 32'd1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wait_ready("store_ready");
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    check("store_err", 32'(Mem_Err), 32'(is_oor(addr)));
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, input int hold);
    int c;
    wait_ready("load_ready");
    Address = addr; MemRead = 1'b1; Read_data_Ready = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    MemRead = 1'b0;
    c = 1;
    while (!Read_data_Valid && c <= 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("load_latency", 32'(c), 32'(LAT));
    check("load_err", 32'(Mem_Err), 32'(is_oor(addr)));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(Read_data_Valid), 32'd1);
      check("hold_busy", 32'(Mem_Req_Ready), 32'd0);
      check("hold_data", Read_data, exp);
      @(posedge clk); #1;
    end
    Read_data_Ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", 32'(Read_data_Valid), 32'd0);
    check("post_ready", 32'(Mem_Req_Ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; Address = '0; MemRead = 1'b0; MemWrite = 1'b0;
    Write_data = '0; Write_strb = '0; Read_data_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(Mem_Req_Ready), 32'd1);
    check("rst_valid", 32'(Read_data_Valid), 32'd0);
    check("rst_data", Read_data, 32'h0);
    check("rst_err", 32'(Mem_Err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_store(32'h100, 32'hDEADBEEF, 4'b1111);
    do_load (32'h100, 32'hDEADBEEF, 0);
    do_store(32'h100, 32'h000000AA, 4'b0001);
    do_load (32'h102, 32'hDEADBEAA, 0);
    do_load (32'h100, 32'hDEADBEAA, 5);

    // Abort a load with reset one cycle after acceptance.
    Address = 32'h100; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_valid", 32'(Read_data_Valid), 32'd0);
      check("abort_ready", 32'(Mem_Req_Ready), 32'd1);
      @(posedge clk); #1;
    end
    do_load(32'h100, 32'hDEADBEAA, 0);

    do_store(32'h0, 32'h11111111, 4'b1111);
    do_store(32'h4, 32'h22222222, 4'b1111);
    do_store(32'h8, 32'h33333333, 4'b1111);
    do_load (32'h0, 32'h11111111, 0);
    do_load (32'h4, 32'h22222222, 0);
    do_load (32'h8, 32'h33333333, 0);

    do_store(32'h1000, 32'h12345678, 4'b1111);
    check("err_pulse_end", 32'(Mem_Err), 32'd0);
    do_load(32'h0,    RC ? 32'h11111111 : 32'h12345678, 0);
    do_load(32'h1000, RC ? 32'h00000000 : 32'h12345678, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
